// File: rtl/atri_samplemon_loader.sv
// atri_samplemon_loader
// Host-driven instruction-memory loader for the sample-monitor sequencer.
// A load session holds the sequencer in reset, writes each host word into
// instruction memory port B, and reads it back to verify it. The sequencer
// is then released after a fixed hold time.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   prog_start_i        one-cycle pulse, opens a load session (IDLE only)
//   prog_done_i         one-cycle pulse, closes a load session
//   wr_valid_i/ready_o  host word handshake, wr_data_i carries the word
//   cpu_reset_o         active-high sequencer reset
//   bram_we_o/addr_o/wdata_o/rdata_i  instruction memory port B (1-cycle read)
//   busy_o              session active
//   verify_err_o        sticky readback mismatch
//   ovf_err_o           sticky write attempt with memory full
//   word_count_o        words written in the current/last session
module atri_samplemon_loader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH = 18,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_start_i,
  input  logic                   prog_done_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [INSTR_WIDTH-1:0] wr_data_i,
  output logic                   cpu_reset_o,
  output logic                   bram_we_o,
  output logic [ADDR_WIDTH-1:0]  bram_addr_o,
  output logic [INSTR_WIDTH-1:0] bram_wdata_o,
  input  logic [INSTR_WIDTH-1:0] bram_rdata_i,
  output logic                   busy_o,
  output logic                   verify_err_o,
  output logic                   ovf_err_o,
  output logic [ADDR_WIDTH:0]    word_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    LOAD,
    WRITE,
    READ,
    CHECK,
    RELEASE
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE   = 1;
  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]          HOLD_INIT = 8'(HOLD_CYCLES);

  state_t                state, state_nxt;
  logic [7:0]            hold_cnt;
  logic [7:0]            boot_cnt;
  logic                  done_pend;
  logic                  accept;
  logic                  full;
  logic                  hold_last;
  logic                  booting;

  assign full      = word_count_o[ADDR_WIDTH];
  assign hold_last = (hold_cnt == HOLD_LAST);
  assign booting   = (boot_cnt != 8'd0);

  // State register. Reset lands in IDLE, but the boot counter keeps the
  // sequencer in reset for HOLD_CYCLES cycles after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode. A latched done request blocks any new
  // accept in LOAD and sends the session straight to RELEASE.
  always_comb begin
    state_nxt   = state;
    wr_ready_o  = 1'b0;
    bram_we_o   = 1'b0;
    cpu_reset_o = 1'b1;
    busy_o      = 1'b1;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        busy_o      = 1'b0;
        cpu_reset_o = booting;
        if (prog_start_i && !booting) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if (hold_last) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        wr_ready_o = !full && !done_pend;
        accept     = wr_valid_i && wr_ready_o;
        if (accept) begin
          state_nxt = WRITE;
        end else if (prog_done_i || done_pend) begin
          state_nxt = RELEASE;
        end
      end
      WRITE: begin
        bram_we_o = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = LOAD;
      end
      RELEASE: begin
        if (hold_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: hold timers, word counter, captured word/address, sticky flags
  // and the pending-done latch. The word counter doubles as the write address;
  // its extra MSB marks a full memory so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt     <= HOLD_INIT;
      hold_cnt     <= 8'd0;
      done_pend    <= 1'b0;
      word_count_o <= '0;
      verify_err_o <= 1'b0;
      ovf_err_o    <= 1'b0;
      bram_addr_o  <= '0;
      bram_wdata_o <= '0;
    end else begin
      if (booting) begin
        boot_cnt <= boot_cnt - 8'd1;
      end
      if (state_nxt != state) begin
        hold_cnt <= 8'd0;
      end else if (state == HALT || state == RELEASE) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (prog_start_i && !booting) begin
            word_count_o <= '0;
            verify_err_o <= 1'b0;
            ovf_err_o    <= 1'b0;
            done_pend    <= 1'b0;
          end
        end
        HALT, WRITE, READ: begin
          if (prog_done_i) begin
            done_pend <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            bram_addr_o  <= word_count_o[ADDR_WIDTH-1:0];
            bram_wdata_o <= wr_data_i;
            if (prog_done_i) begin
              done_pend <= 1'b1;
            end
          end else if (prog_done_i || done_pend) begin
            done_pend <= 1'b0;
          end
          if (full && wr_valid_i) begin
            ovf_err_o <= 1'b1;
          end
        end
        CHECK: begin
          if (prog_done_i) begin
            done_pend <= 1'b1;
          end
          if (bram_rdata_i != bram_wdata_o) begin
            verify_err_o <= 1'b1;
          end
          word_count_o <= word_count_o + CNT_ONE;
        end
        RELEASE: begin
          done_pend <= 1'b0;
        end
        default: begin
          done_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atri_samplemon_loader.sv
// Directed self-checking bench for atri_samplemon_loader. A behavioural
// port-B memory model with optional fault injection sits on the BRAM port.
module tb_atri_samplemon_loader;

  localparam int AW   = 10;
  localparam int IW   = 18;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          prog_start_i = 1'b0;
  logic          prog_done_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [IW-1:0] wr_data_i = '0;
  logic          cpu_reset_o;
  logic          bram_we_o;
  logic [AW-1:0] bram_addr_o;
  logic [IW-1:0] bram_wdata_o;
  logic [IW-1:0] bram_rdata_i = '0;
  logic          busy_o;
  logic          verify_err_o;
  logic          ovf_err_o;
  logic [AW:0]   word_count_o;

  logic [IW-1:0] mem [0:(1<<AW)-1];
  logic          faultEn = 1'b0;
  int            wrCnt = 0;
  int            errCnt = 0;
  int            chkCnt = 0;
  int            expAddr = 0;
  int            wrBefore;

  atri_samplemon_loader #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_start_i(prog_start_i),
    .prog_done_i (prog_done_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .cpu_reset_o (cpu_reset_o),
    .bram_we_o   (bram_we_o),
    .bram_addr_o (bram_addr_o),
    .bram_wdata_o(bram_wdata_o),
    .bram_rdata_i(bram_rdata_i),
    .busy_o      (busy_o),
    .verify_err_o(verify_err_o),
    .ovf_err_o   (ovf_err_o),
    .word_count_o(word_count_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Port-B memory model: synchronous write, registered read with one cycle
  // of latency; faultEn makes address 1 read back as zero.
  always @(posedge clk) begin
    if (bram_we_o) begin
      mem[bram_addr_o] <= bram_wdata_o;
      wrCnt            <= wrCnt + 1;
    end
    bram_rdata_i <= (faultEn && bram_addr_o == 1) ? '0 : mem[bram_addr_o];
  end

  // Watchdog so a stuck design still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errCnt, chkCnt);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Asserts reset from the current negedge, checks the reset values, then
  // releases it with a start pulse that must be ignored during the hold.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rstCpuReset", cpu_reset_o, 1);
    checkOutput("rstWe", bram_we_o, 0);
    checkOutput("rstReady", wr_ready_o, 0);
    checkOutput("rstBusy", busy_o, 0);
    checkOutput("rstAddr", bram_addr_o, 0);
    checkOutput("rstWdata", bram_wdata_o, 0);
    checkOutput("rstCount", word_count_o, 0);
    checkOutput("rstVerify", verify_err_o, 0);
    checkOutput("rstOvf", ovf_err_o, 0);
    tick();
    rst_n = 1'b1;
    prog_start_i = 1'b1;
    tick();
    prog_start_i = 1'b0;
    checkOutput("bootStartIgnored", busy_o, 0);
    checkOutput("bootCpuReset", cpu_reset_o, 1);
    tick();
    tick();
    checkOutput("bootHoldLast", cpu_reset_o, 1);
    tick();
    checkOutput("bootDone", cpu_reset_o, 0);
    checkOutput("bootBusy", busy_o, 0);
  endtask

  // Opens a session from IDLE and walks through HALT into LOAD
  task automatic startSession();
    prog_start_i = 1'b1;
    tick();
    prog_start_i = 1'b0;
    checkOutput("haltBusy", busy_o, 1);
    checkOutput("haltCpuReset", cpu_reset_o, 1);
    checkOutput("haltReady", wr_ready_o, 0);
    checkOutput("haltVerifyClr", verify_err_o, 0);
    checkOutput("haltOvfClr", ovf_err_o, 0);
    checkOutput("haltCountClr", word_count_o, 0);
    for (int i = 0; i < HOLD; i++) tick();
    checkOutput("loadReady", wr_ready_o, 1);
    expAddr = 0;
  endtask

  // Sends one word and follows it through WRITE/READ/CHECK back to LOAD.
  // doneAt: 0 = no done, 1 = done with the accept, 2 = done during WRITE.
  task automatic applyStimulus(input logic [IW-1:0] data, input int doneAt);
    int n;
    n = 0;
    while (wr_ready_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (wr_ready_o !== 1'b1) begin
      checkOutput("readyTimeout", 0, 1);
      return;
    end
    wr_valid_i   = 1'b1;
    wr_data_i    = data;
    prog_done_i  = (doneAt == 1);
    tick();
    wr_valid_i   = 1'b0;
    prog_done_i  = (doneAt == 2);
    checkOutput("writeWe", bram_we_o, 1);
    checkOutput("writeAddr", bram_addr_o, expAddr);
    checkOutput("writeData", bram_wdata_o, data);
    checkOutput("writeReady", wr_ready_o, 0);
    tick();
    prog_done_i = 1'b0;
    checkOutput("readWe", bram_we_o, 0);
    checkOutput("readAddr", bram_addr_o, expAddr);
    checkOutput("readReady", wr_ready_o, 0);
    tick();
    checkOutput("checkReady", wr_ready_o, 0);
    checkOutput("checkCpuReset", cpu_reset_o, 1);
    tick();
    expAddr++;
  endtask

  // Called at the first negedge inside RELEASE
  task automatic releaseCheck();
    checkOutput("relBusy", busy_o, 1);
    checkOutput("relWe", bram_we_o, 0);
    for (int i = 0; i < HOLD; i++) begin
      if (i == HOLD - 1) checkOutput("relCpuResetLast", cpu_reset_o, 1);
      tick();
    end
    checkOutput("relCpuResetLow", cpu_reset_o, 0);
    checkOutput("relIdle", busy_o, 0);
  endtask

  task automatic finishSession();
    prog_done_i = 1'b1;
    tick();
    prog_done_i = 1'b0;
    releaseCheck();
  endtask

  initial begin
    #2;
    doReset();

    // Basic three-word load
    wrBefore = wrCnt;
    startSession();
    applyStimulus(18'h3_0001, 0);
    checkOutput("basicVerify0", verify_err_o, 0);
    applyStimulus(18'h0_1234, 0);
    applyStimulus(18'h2_ABCD, 0);
    checkOutput("basicReadyAgain", wr_ready_o, 1);
    finishSession();
    checkOutput("basicCount", word_count_o, 3);
    checkOutput("basicVerify", verify_err_o, 0);
    checkOutput("basicOvf", ovf_err_o, 0);
    checkOutput("basicWrites", wrCnt - wrBefore, 3);
    checkOutput("basicMem0", mem[0], 18'h3_0001);
    checkOutput("basicMem1", mem[1], 18'h0_1234);
    checkOutput("basicMem2", mem[2], 18'h2_ABCD);

    // Readback fault at address 1
    faultEn = 1'b1;
    startSession();
    applyStimulus(18'h3_0001, 0);
    checkOutput("faultAfterW0", verify_err_o, 0);
    applyStimulus(18'h0_1234, 0);
    checkOutput("faultAfterW1", verify_err_o, 1);
    applyStimulus(18'h2_ABCD, 0);
    finishSession();
    checkOutput("faultIdleSticky", verify_err_o, 1);
    checkOutput("faultCount", word_count_o, 3);
    faultEn = 1'b0;

    // Done pulsed during WRITE: word finishes, then RELEASE without accepting
    startSession();
    wrBefore = wrCnt;
    applyStimulus(18'h1_5555, 2);
    checkOutput("pendReady", wr_ready_o, 0);
    checkOutput("pendCount", word_count_o, 1);
    wr_valid_i = 1'b1;
    wr_data_i  = 18'h0_0BAD;
    tick();
    wr_valid_i = 1'b0;
    releaseCheck();
    checkOutput("pendWrites", wrCnt - wrBefore, 1);
    checkOutput("pendVerify", verify_err_o, 0);
    checkOutput("pendMem0", mem[0], 18'h1_5555);

    // Accept and done in the same LOAD cycle
    startSession();
    wrBefore = wrCnt;
    applyStimulus(18'h2_0F0F, 1);
    checkOutput("simReady", wr_ready_o, 0);
    tick();
    releaseCheck();
    checkOutput("simWrites", wrCnt - wrBefore, 1);
    checkOutput("simCount", word_count_o, 1);
    checkOutput("simMem0", mem[0], 18'h2_0F0F);

    // Fill all 1024 words, then one extra valid must overflow
    startSession();
    wrBefore = wrCnt;
    for (int i = 0; i < (1 << AW); i++) applyStimulus(18'((i * 37 + 5) & 18'h3FFFF), 0);
    checkOutput("fullWrites", wrCnt - wrBefore, 1 << AW);
    checkOutput("fullCount", word_count_o, 1 << AW);
    checkOutput("fullReady", wr_ready_o, 0);
    checkOutput("fullOvfBefore", ovf_err_o, 0);
    checkOutput("fullMemLast", mem[1023], 18'((1023 * 37 + 5) & 18'h3FFFF));
    wr_valid_i = 1'b1;
    wr_data_i  = 18'h3_FFFF;
    tick();
    wr_valid_i = 1'b0;
    checkOutput("ovfSet", ovf_err_o, 1);
    checkOutput("ovfStillLoad", busy_o, 1);
    checkOutput("ovfNoWe", bram_we_o, 0);
    tick();
    checkOutput("ovfNoWrite", wrCnt - wrBefore, 1 << AW);
    finishSession();
    checkOutput("ovfIdleSticky", ovf_err_o, 1);
    checkOutput("ovfIdleCount", word_count_o, 1 << AW);

    // Reset asserted in READ aborts the session
    startSession();
    applyStimulus(18'h0_00AA, 0);
    wrBefore = wrCnt;
    wr_valid_i = 1'b1;
    wr_data_i  = 18'h0_00BB;
    tick();
    wr_valid_i = 1'b0;
    checkOutput("abortWriteWe", bram_we_o, 1);
    tick();
    checkOutput("abortInRead", bram_we_o, 0);
    doReset();
    checkOutput("abortCount", word_count_o, 0);
    checkOutput("abortWrites", wrCnt - wrBefore, 1);
    tick();
    checkOutput("abortNoWrite", wrCnt - wrBefore, 1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
